tx_frame_gen: RTL and testbench

TX_FRAME_GEN -- requirements
Module: tx_frame_gen

---
 rtl/tx_frame_gen.sv | 154 +++++++++++++++
 tb/tb_tx_frame_gen.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_gen.sv
// Frame generator: pulls BURST_LEN bytes from a tx_fifo and emits
// SOF, length, payload and an 8-bit additive checksum as a valid/ready stream.
module tx_frame_gen #(
  parameter int         DATA_WIDTH = 8,
  parameter int         BURST_LEN  = 16,
  parameter logic [7:0] SOF_BYTE   = 8'hA5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  output logic                  o_pop,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  i_aempty,
  output logic [7:0]            o_tdata,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic                  o_tlast,
  output logic                  o_busy,
  output logic [15:0]           o_frame_cnt
);

  localparam logic [7:0] LEN_B = 8'(BURST_LEN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM
  } state_t;

  state_t                state_reg;
  logic [7:0]            tdata_reg;
  logic                  tvalid_reg;
  logic                  tlast_reg;
  logic [15:0]           frame_cnt_reg;
  logic [DATA_WIDTH-1:0] pbuf_reg [2];
  logic [1:0]            occ_reg;
  logic                  inflight_reg;
  logic [7:0]            pop_cnt_reg;
  logic [7:0]            load_cnt_reg;
  logic [7:0]            csum_reg;

  logic                  xfer;
  logic                  pop_ok;
  logic                  load;
  logic                  from_buf;
  logic                  push;
  logic [DATA_WIDTH-1:0] next_byte;

  assign xfer      = tvalid_reg & i_tready;
  assign pop_ok    = ((state_reg == ST_SOF) || (state_reg == ST_LEN) || (state_reg == ST_PAYLOAD))
                     && (pop_cnt_reg < LEN_B)
                     && ((occ_reg + {1'b0, inflight_reg}) < 2'd2);
  // A pop during a reset cycle would lose a byte that nobody will capture.
  assign o_pop     = i_rst_n & pop_ok;
  assign load      = xfer && ((state_reg == ST_LEN) ||
                              ((state_reg == ST_PAYLOAD) && (load_cnt_reg < LEN_B)));
  assign from_buf  = (occ_reg != 2'd0);
  assign next_byte = from_buf ? pbuf_reg[0] : i_rdata;
  // Arriving data bypasses the buffer when it is loaded straight into the output.
  assign push      = inflight_reg && !(load && !from_buf);

  assign o_tdata     = tdata_reg;
  assign o_tvalid    = tvalid_reg;
  assign o_tlast     = tlast_reg;
  assign o_busy      = (state_reg != ST_IDLE);
  assign o_frame_cnt = frame_cnt_reg;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg     <= ST_IDLE;
      tdata_reg     <= '0;
      tvalid_reg    <= 1'b0;
      tlast_reg     <= 1'b0;
      frame_cnt_reg <= '0;
      pbuf_reg[0]   <= '0;
      pbuf_reg[1]   <= '0;
      occ_reg       <= '0;
      inflight_reg  <= 1'b0;
      pop_cnt_reg   <= '0;
      load_cnt_reg  <= '0;
      csum_reg      <= '0;
    end else begin
      inflight_reg <= o_pop;
      if (o_pop) pop_cnt_reg <= pop_cnt_reg + 8'd1;

      // Occupancy never exceeds one when data arrives, so push lands in slot 0 or 1.
      if (load && from_buf) begin
        if (push) begin
          pbuf_reg[0] <= i_rdata;
        end else begin
          pbuf_reg[0] <= pbuf_reg[1];
          occ_reg     <= occ_reg - 2'd1;
        end
      end else if (push) begin
        pbuf_reg[occ_reg[0]] <= i_rdata;
        occ_reg              <= occ_reg + 2'd1;
      end

      if (load) begin
        csum_reg     <= csum_reg + next_byte[7:0];
        load_cnt_reg <= load_cnt_reg + 8'd1;
      end

      case (state_reg)
        ST_IDLE: begin
          if (!i_aempty) begin
            state_reg    <= ST_SOF;
            tvalid_reg   <= 1'b1;
            tdata_reg    <= SOF_BYTE;
            tlast_reg    <= 1'b0;
            pop_cnt_reg  <= '0;
            load_cnt_reg <= '0;
            csum_reg     <= '0;
          end
        end
        ST_SOF: begin
          if (xfer) begin
            state_reg <= ST_LEN;
            tdata_reg <= LEN_B;
          end
        end
        ST_LEN: begin
          if (xfer) begin
            state_reg <= ST_PAYLOAD;
            tdata_reg <= next_byte[7:0];
          end
        end
        ST_PAYLOAD: begin
          if (xfer) begin
            if (load) begin
              tdata_reg <= next_byte[7:0];
            end else begin
              state_reg <= ST_CSUM;
              tdata_reg <= csum_reg;
              tlast_reg <= 1'b1;
            end
          end
        end
        ST_CSUM: begin
          if (xfer) begin
            state_reg     <= ST_IDLE;
            tvalid_reg    <= 1'b0;
            tlast_reg     <= 1'b0;
            tdata_reg     <= '0;
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_gen.sv
// Directed bench for tx_frame_gen: tx_fifo model, stream monitor and
// scenario tasks with hand-computed expected frames.
module tb_tx_frame_gen;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        o_pop;
  logic [7:0]  i_rdata = '0;
  logic        i_aempty = 1'b1;
  logic [7:0]  o_tdata;
  logic        o_tvalid;
  logic        i_tready = 1'b1;
  logic        o_tlast;
  logic        o_busy;
  logic [15:0] o_frame_cnt;

  int tests = 0;
  int fails = 0;

  logic [7:0] fq[$];
  logic [7:0] cap_d[$];
  logic       cap_l[$];
  int         cap_c[$];
  int  cyc = 0;
  bit  pend = 0;
  int  pop_total = 0;
  int  underflow = 0;
  int  stall_viol = 0;
  bit  stall_prev = 0;
  logic [7:0] prev_d = '0;
  logic prev_l = 0;
  bit  busy_prev = 0;
  bit  tv_prev = 0;
  int  starts = 0;
  int  done = 0;
  int  fv_cyc = -1;

  tx_frame_gen #(.DATA_WIDTH(8), .BURST_LEN(16), .SOF_BYTE(8'hA5)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .o_pop(o_pop), .i_rdata(i_rdata),
    .i_aempty(i_aempty), .o_tdata(o_tdata), .o_tvalid(o_tvalid),
    .i_tready(i_tready), .o_tlast(o_tlast), .o_busy(o_busy),
    .o_frame_cnt(o_frame_cnt)
  );

  always #5 i_clk = ~i_clk;

  // FIFO read side (data valid the cycle after a pop) plus stream monitor.
  always @(negedge i_clk) begin
    cyc++;
    if (pend) begin
      if (fq.size() > 0) i_rdata = fq.pop_front();
      else begin i_rdata = '0; underflow++; end
    end
    pend = o_pop;
    if (o_pop) pop_total++;
    if (stall_prev && (o_tvalid !== 1'b1 || o_tdata !== prev_d || o_tlast !== prev_l))
      stall_viol++;
    stall_prev = o_tvalid && !i_tready;
    prev_d = o_tdata;
    prev_l = o_tlast;
    if (o_busy && !busy_prev) starts++;
    busy_prev = o_busy;
    if (o_tvalid && !tv_prev) fv_cyc = cyc;
    tv_prev = o_tvalid;
    if (o_tvalid && i_tready) begin
      cap_d.push_back(o_tdata);
      cap_l.push_back(o_tlast);
      cap_c.push_back(cyc);
      if (o_tlast) done++;
    end
  end

  task automatic clear_capture();
    cap_d.delete(); cap_l.delete(); cap_c.delete();
    pop_total = 0; stall_viol = 0;
  endtask

  task automatic load_fifo(input logic [7:0] base, input logic [7:0] step, input int n);
    logic [7:0] v;
    v = base;
    for (int i = 0; i < n; i++) begin
      fq.push_back(v);
      v = v + step;
    end
  endtask

  // Builds the expected frame for 16 payload bytes base, base+step, ...
  task automatic expect_frame(input logic [7:0] base, input logic [7:0] step,
                              inout logic [7:0] exp_q[$]);
    logic [7:0] v;
    logic [7:0] s;
    v = base; s = 8'h00;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h10);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(v);
      s = s + v;
      v = v + step;
    end
    exp_q.push_back(s);
  endtask

  task automatic run_frames(input int n, input bit toggle, output int aempty_cyc);
    int target;
    int st0;
    int k;
    target = done + n;
    st0 = starts;
    @(posedge i_clk); #1;
    i_tready = 1'b1;
    i_aempty = 1'b0;
    aempty_cyc = cyc;
    for (k = 0; k < 2000; k++) begin
      @(posedge i_clk); #1;
      if (toggle) i_tready = ~i_tready;
      if (starts - st0 >= n) i_aempty = 1'b1;
      if (done >= target) break;
    end
    i_aempty = 1'b1;
    i_tready = 1'b1;
    tests++;
    if (k >= 2000) begin
      fails++;
      $display("FAIL timeout: frames done %0d, required %0d", done, target);
    end
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    tests++;
    if ({o_pop, o_tvalid, o_tlast, o_busy} !== 4'b0 || o_tdata !== 8'h00 || o_frame_cnt !== 16'h0) begin
      fails++;
      $display("FAIL reset_outputs: pop=%b tvalid=%b tlast=%b busy=%b tdata=%h cnt=%h, required all 0",
               o_pop, o_tvalid, o_tlast, o_busy, o_tdata, o_frame_cnt);
    end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_basic();
    logic [7:0] exp_q[$];
    int ae, nbad, nlast;
    clear_capture();
    load_fifo(8'h01, 8'h01, 16);
    expect_frame(8'h01, 8'h01, exp_q);
    run_frames(1, 1'b0, ae);
    nbad = 0; nlast = 0;
    foreach (exp_q[i]) if (i >= cap_d.size() || cap_d[i] !== exp_q[i]) nbad++;
    foreach (cap_l[i]) if (cap_l[i]) nlast++;
    tests++;
    if (cap_d.size() != 19 || nbad != 0) begin
      fails++;
      $display("FAIL basic_seq: %0d bytes, %0d wrong, required 19 bytes A5,10,01..10,88", cap_d.size(), nbad);
    end
    tests++;
    if (cap_d.size() == 19 && cap_d[18] !== 8'h88) begin
      fails++;
      $display("FAIL basic_csum: got %h, required 88", cap_d[18]);
    end
    tests++;
    if (cap_c.size() != 19 || cap_c[18] - cap_c[0] != 18) begin
      fails++;
      $display("FAIL basic_consecutive: %0d transfers, span not 18 cycles", cap_c.size());
    end
    tests++;
    if (nlast != 1 || cap_l.size() != 19 || cap_l[18] !== 1'b1) begin
      fails++;
      $display("FAIL basic_tlast: %0d tlast beats, required exactly 1 on final byte", nlast);
    end
    tests++;
    if (fv_cyc != ae + 2) begin
      fails++;
      $display("FAIL first_valid: rose at cycle %0d, required %0d", fv_cyc, ae + 2);
    end
    tests++;
    if (o_frame_cnt !== 16'd1 || pop_total != 16) begin
      fails++;
      $display("FAIL basic_counts: frame_cnt=%0d pops=%0d, required 1 and 16", o_frame_cnt, pop_total);
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp_q[$];
    int ae, nbad;
    clear_capture();
    load_fifo(8'h01, 8'h01, 16);
    expect_frame(8'h01, 8'h01, exp_q);
    run_frames(1, 1'b1, ae);
    nbad = 0;
    foreach (exp_q[i]) if (i >= cap_d.size() || cap_d[i] !== exp_q[i]) nbad++;
    tests++;
    if (cap_d.size() != 19 || nbad != 0) begin
      fails++;
      $display("FAIL stall_seq: %0d bytes, %0d wrong, required 19 matching", cap_d.size(), nbad);
    end
    tests++;
    if (stall_viol != 0) begin
      fails++;
      $display("FAIL stall_stable: %0d unstable stall cycles, required 0", stall_viol);
    end
    tests++;
    if (pop_total != 16 || o_frame_cnt !== 16'd2) begin
      fails++;
      $display("FAIL stall_counts: pops=%0d frame_cnt=%0d, required 16 and 2", pop_total, o_frame_cnt);
    end
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    i_aempty = 1'b1;
    repeat (100) begin
      @(negedge i_clk);
      if (o_busy || o_pop || o_tvalid) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL idle_quiet: %0d active cycles, required 0", bad);
    end
  endtask

  task automatic test_csum_wrap();
    int ae;
    clear_capture();
    load_fifo(8'hFF, 8'h00, 16);
    run_frames(1, 1'b0, ae);
    tests++;
    if (cap_d.size() != 19 || cap_d[18] !== 8'hF0) begin
      fails++;
      $display("FAIL csum_wrap: %0d bytes, last=%h, required F0",
               cap_d.size(), cap_d.size() > 0 ? cap_d[cap_d.size()-1] : 8'h00);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    int ae, nbad;
    clear_capture();
    load_fifo(8'h20, 8'h03, 32);
    expect_frame(8'h20, 8'h03, exp_q);
    expect_frame(8'h50, 8'h03, exp_q);
    run_frames(2, 1'b0, ae);
    nbad = 0;
    foreach (exp_q[i]) if (i >= cap_d.size() || cap_d[i] !== exp_q[i]) nbad++;
    tests++;
    if (cap_d.size() != 38 || nbad != 0) begin
      fails++;
      $display("FAIL b2b_seq: %0d bytes, %0d wrong, required 38 matching", cap_d.size(), nbad);
    end
    tests++;
    if (cap_c.size() != 38 || cap_c[19] - cap_c[18] != 2) begin
      fails++;
      $display("FAIL b2b_gap: gap between frames not one idle cycle (%0d transfers)", cap_c.size());
    end
    tests++;
    if (o_frame_cnt !== 16'd5) begin
      fails++;
      $display("FAIL b2b_cnt: frame_cnt=%0d, required 5", o_frame_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_q[$];
    int ae, k, nbad;
    clear_capture();
    load_fifo(8'h01, 8'h01, 16);
    @(posedge i_clk); #1;
    i_aempty = 1'b0;
    for (k = 0; k < 200; k++) begin
      @(posedge i_clk); #1;
      i_aempty = 1'b1;
      if (o_tvalid && o_tdata == 8'h05) break;
    end
    i_rst_n = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    tests++;
    if (k >= 200 || {o_pop, o_tvalid, o_tlast, o_busy} !== 4'b0 || o_tdata !== 8'h00 || o_frame_cnt !== 16'h0) begin
      fails++;
      $display("FAIL mid_reset: pop=%b tvalid=%b tlast=%b busy=%b tdata=%h cnt=%h, required all 0",
               o_pop, o_tvalid, o_tlast, o_busy, o_tdata, o_frame_cnt);
    end
    @(posedge i_clk); #1;
    fq.delete();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    clear_capture();
    load_fifo(8'h01, 8'h01, 16);
    expect_frame(8'h01, 8'h01, exp_q);
    run_frames(1, 1'b0, ae);
    nbad = 0;
    foreach (exp_q[i]) if (i >= cap_d.size() || cap_d[i] !== exp_q[i]) nbad++;
    tests++;
    if (cap_d.size() != 19 || nbad != 0 || o_frame_cnt !== 16'd1) begin
      fails++;
      $display("FAIL post_reset_frame: %0d bytes, %0d wrong, frame_cnt=%0d, required 19 matching and 1",
               cap_d.size(), nbad, o_frame_cnt);
    end
  endtask

  task automatic test_cnt_wrap();
    int ae;
    @(negedge i_clk);
    dut.frame_cnt_reg = 16'hFFFE;
    clear_capture();
    load_fifo(8'h01, 8'h01, 16);
    run_frames(1, 1'b0, ae);
    tests++;
    if (o_frame_cnt !== 16'hFFFF) begin
      fails++;
      $display("FAIL cnt_ffff: frame_cnt=%h, required FFFF", o_frame_cnt);
    end
    clear_capture();
    load_fifo(8'h01, 8'h01, 16);
    run_frames(1, 1'b0, ae);
    tests++;
    if (o_frame_cnt !== 16'h0000) begin
      fails++;
      $display("FAIL cnt_wrap: frame_cnt=%h, required 0000", o_frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_idle();
    test_csum_wrap();
    test_back_to_back();
    test_reset_mid();
    test_cnt_wrap();
    tests++;
    if (underflow != 0 || fq.size() != 0) begin
      fails++;
      $display("FAIL fifo_balance: underflows=%0d leftover=%0d, required 0 and 0", underflow, fq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
